// File: rtl/fifo_stream_reader.sv
`timescale 1ns/1ps
// Purpose : read-side controller for the 8-bit FIFO. It pops words and presents them as an ordered valid/ready stream.
// Latency : fifo_read in cycle t gives out_valid in cycle t+2. A consumer that is always ready gets one word per cycle.
// Backpress: a 2-entry skid buffer absorbs the 1-cycle FIFO read latency. Reads stop while buffered plus in-flight words would exceed 2.
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   reset      asynchronous, active-low; 0 clears all state immediately
//   fifo_empty FIFO empty flag
//   fifo_data  FIFO output bus; valid the cycle after a fifo_read pulse
//   fifo_read  FIFO read strobe (combinational); one word popped per high cycle
//   out_data   head word of the stream (oldest buffered word)
//   out_valid  out_data holds a valid word
//   out_ready  consumer accepts out_data this cycle
//   occupancy  skid-buffer occupancy, 0..2
//   words_out  wrapping count of delivered words (valid & ready)
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  words_out
);

    // Buffer occupancy states
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    logic [1:0]            occ_q,      occ_d;
    logic [DATA_WIDTH-1:0] ent0_q,     ent0_d;    // head of stream
    logic [DATA_WIDTH-1:0] ent1_q,     ent1_d;    // second-oldest word
    logic                  valid_q,    valid_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;

    logic                  pop;
    logic                  capture;
    logic [2:0]            credit_use;

    assign pop     = valid_q & out_ready;
    // A word read last cycle arrives on fifo_data this cycle.
    assign capture = inflight_q;

    // Count words already owned after this cycle's pop: buffered plus the one in flight.
    // Pop implies occ_q >= 1, so the subtraction cannot underflow.
    assign credit_use = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    // The reset term holds the strobe low during reset.
    // The request only depends on registered state plus fifo_empty/out_ready.
    assign fifo_read = reset & ~fifo_empty & (credit_use < 3'd2);

    always_comb begin
        occ_d      = occ_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        inflight_d = fifo_read;
        cnt_d      = cnt_q + CNT_WIDTH'(pop);

        case ({capture, pop})
            2'b10: begin
                case (occ_q)
                    OCC_EMPTY: begin
                        ent0_d = fifo_data;
                        occ_d  = OCC_ONE;
                    end
                    OCC_ONE: begin
                        ent1_d = fifo_data;
                        occ_d  = OCC_TWO;
                    end
                    // Capture into a full buffer cannot occur under the credit rule.
                    // If it does, the word is dropped and the assertion below fires.
                    default: ;
                endcase
            end
            2'b01: begin
                // Strict order: entry 1 shifts into the head slot.
                ent0_d = ent1_q;
                case (occ_q)
                    OCC_ONE: occ_d = OCC_EMPTY;
                    OCC_TWO: occ_d = OCC_ONE;
                    default: ;
                endcase
            end
            2'b11: begin
                case (occ_q)
                    // Head leaves and the arriving word takes its place directly.
                    OCC_ONE: ent0_d = fifo_data;
                    OCC_TWO: begin
                        ent0_d = ent1_q;
                        ent1_d = fifo_data;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        valid_d = (occ_d != OCC_EMPTY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q      <= OCC_EMPTY;
            ent0_q     <= '0;
            ent1_q     <= '0;
            valid_q    <= 1'b0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            valid_q    <= valid_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_data  = ent0_q;
    assign out_valid = valid_q;
    assign occupancy = occ_q;
    assign words_out = cnt_q;

    // A word must never arrive while both entries are occupied.
    a_no_capture_in_two: assert property (
        @(posedge clk) disable iff (!reset) !(inflight_q && (occ_q == OCC_TWO)));

    // A stalled head word must stay put until accepted.
    a_hold_when_stalled: assert property (
        @(posedge clk) disable iff (!reset)
        (valid_q && !out_ready) |=> (valid_q && $stable(ent0_q)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
`timescale 1ns/1ps
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_read;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] occupancy;
    logic [15:0] words_out;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO: words are returned on fifo_data the cycle after a read.
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int empty_read_viol = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
        if (fifo_read && fifo_empty)
            empty_read_viol <= empty_read_viol + 1;
    end

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .occupancy  (occupancy),
        .words_out  (words_out)
    );

    task automatic push(input logic [7:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with 0x00..0x03 preloaded, then a 4-word burst from release.
    task automatic test_reset();
        logic [6:0] exp_rd;
        logic [6:0] exp_vld;
        exp_rd  = 7'b0001111;
        exp_vld = 7'b0111100;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(i));
        step(); step();
        #2;
        checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL rst_fifo_read got %b exp 0", fifo_read); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h exp 00", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy got %0d exp 0", occupancy); end
        checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL rst_words_out got %0d exp 0", words_out); end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #2;
            checks++;
            if (fifo_read !== exp_rd[c]) begin errors++; $display("FAIL burst_fifo_read c%0d got %b exp %b", c, fifo_read, exp_rd[c]); end
            checks++;
            if (out_valid !== exp_vld[c]) begin errors++; $display("FAIL burst_out_valid c%0d got %b exp %b", c, out_valid, exp_vld[c]); end
            if (exp_vld[c]) begin
                checks++;
                if (out_data !== 8'(c - 2)) begin errors++; $display("FAIL burst_out_data c%0d got %h exp %h", c, out_data, 8'(c - 2)); end
            end
            step();
        end
        #2;
        checks++; if (words_out !== 16'd4) begin errors++; $display("FAIL burst_words_out got %0d exp 4", words_out); end
        step();
    endtask

    // Single word 0xA5 held for 10 cycles with out_ready low, then accepted.
    task automatic test_hold();
        int base;
        base = rd_ptr;
        out_ready = 1'b0;
        push(8'hA5);
        step(); step();
        for (int c = 0; c < 10; c++) begin
            #2;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL hold c%0d got vld=%b dat=%h occ=%0d exp vld=1 dat=a5 occ=1", c, out_valid, out_data, occupancy);
            end
            step();
        end
        checks++; if (rd_ptr - base !== 1) begin errors++; $display("FAIL hold_reads got %0d exp 1", rd_ptr - base); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_after_pop_valid got %b exp 0", out_valid); end
        checks++; if (words_out !== 16'd5) begin errors++; $display("FAIL hold_words_out got %0d exp 5", words_out); end
        step();
    endtask

    // Five words with consumer stalled: exactly two reads, then gap-free drain.
    task automatic test_full_stall();
        int base;
        base = rd_ptr;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        for (int c = 0; c < 6; c++) step();
        #2;
        checks++; if (rd_ptr - base !== 2) begin errors++; $display("FAIL full_reads got %0d exp 2", rd_ptr - base); end
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL full_occupancy got %0d exp 2", occupancy); end
        checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL full_fifo_read got %b exp 0", fifo_read); end
        checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL full_head got %h exp 10", out_data); end
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #2;
            checks++;
            if (out_valid !== (k < 5)) begin errors++; $display("FAIL drain_valid k%0d got %b exp %b", k, out_valid, (k < 5)); end
            if (k < 5) begin
                checks++;
                if (out_data !== 8'(8'h10 + k)) begin errors++; $display("FAIL drain_data k%0d got %h exp %h", k, out_data, 8'(8'h10 + k)); end
            end
            step();
        end
        #2;
        checks++; if (words_out !== 16'd10) begin errors++; $display("FAIL drain_words_out got %0d exp 10", words_out); end
        step();
    endtask

    // 16-word burst with out_ready alternating 1,0,1,0.
    task automatic test_toggle_ready();
        int got;
        got = 0;
        for (int i = 0; i < 16; i++) push(8'(i));
        for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
            out_ready = (cyc % 2 == 0);
            #2;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== 8'(got)) begin errors++; $display("FAIL toggle_data n%0d got %h exp %h", got, out_data, 8'(got)); end
                got++;
            end
            step();
        end
        checks++; if (got !== 16) begin errors++; $display("FAIL toggle_count got %0d exp 16", got); end
        out_ready = 1'b1;
        step(); step(); step();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL toggle_extra_valid got %b exp 0", out_valid); end
        checks++; if (words_out !== 16'd26) begin errors++; $display("FAIL toggle_words_out got %0d exp 26", words_out); end
        checks++; if (empty_read_viol !== 0) begin errors++; $display("FAIL read_while_empty got %0d exp 0", empty_read_viol); end
        step();
    endtask

    // Reset in the cycle after a read: in-flight word must not be captured.
    task automatic test_reset_midflight();
        out_ready = 1'b0;
        push(8'h21);
        push(8'h22);
        #2;
        checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL mid_read0 got %b exp 1", fifo_read); end
        step();
        #2;
        checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL mid_read1 got %b exp 1", fifo_read); end
        step();
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL mid_pre_occ got %0d exp 1", occupancy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL mid_rst_occ got %0d exp 0", occupancy); end
        checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL mid_rst_words got %0d exp 0", words_out); end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            #2;
            checks++;
            if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
                errors++;
                $display("FAIL mid_no_capture c%0d got vld=%b occ=%0d exp vld=0 occ=0", c, out_valid, occupancy);
            end
        end
        step();
    endtask

    // 65535 pops then one more: counter wraps to zero.
    task automatic test_counter_wrap();
        int n;
        int pushed;
        bit done;
        n = 0;
        pushed = 0;
        done = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 70000 && !done; cyc++) begin
            if (wr_ptr - rd_ptr < 4) begin
                push(8'(pushed));
                pushed++;
            end
            #2;
            if (out_valid && out_ready) n++;
            step();
            if (n == 65535) done = 1;
        end
        out_ready = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL wrap_budget got %0d pops exp 65535", n); end
        #2;
        checks++; if (words_out !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffff", words_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_head_valid got %b exp 1", out_valid); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #2;
        checks++; if (words_out !== 16'h0000) begin errors++; $display("FAIL wrap_post got %h exp 0000", words_out); end
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hold();
        test_full_stall();
        test_toggle_ready();
        test_reset_midflight();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
